// File: rtl/axioma_dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM state encoding,
// owner codes and the arbitration/counter helpers.
package axioma_dmem_arbiter_pkg;

  // Arbiter FSM: one transaction at a time, IDLE -> ACCESS -> RESP -> IDLE.
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_e;

  // Owner codes as seen on the owner output.
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_AUX = 1'b1;

  // Starvation and watchdog counters are both 8 bits wide.
  localparam int unsigned CNT_W = 8;

  // AUX wins when it is pending and either has been starved long enough or the CPU is idle.
  function automatic logic aux_takes_port(input logic             cpu_pend,
                                          input logic             aux_pend,
                                          input logic [CNT_W-1:0] starve_cnt,
                                          input logic [CNT_W-1:0] starve_limit);
    return aux_pend && ((starve_cnt >= starve_limit) || !cpu_pend);
  endfunction

  // Increment that sticks at the top of the counter range.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/axioma_dmem_arbiter_if.sv
// Bus bundle around the arbiter: CPU requester, AUX requester, SRAM side and status.
// The arbiter takes the slave view (it serves both requesters and drives the SRAM);
// the surrounding system takes the master view.
interface axioma_dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
) ();

  // CPU load/store port
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_read;
  logic              cpu_write;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ready;

  // Auxiliary requester (DMA / debug)
  logic [ADDR_W-1:0] aux_addr;
  logic [DATA_W-1:0] aux_wdata;
  logic              aux_read;
  logic              aux_write;
  logic [DATA_W-1:0] aux_rdata;
  logic              aux_ready;

  // SRAM controller port
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  // Status
  logic              owner;
  logic              err;

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_read, cpu_write,
    output cpu_rdata, cpu_ready,
    input  aux_addr, aux_wdata, aux_read, aux_write,
    output aux_rdata, aux_ready,
    output mem_addr, mem_wdata, mem_read, mem_write,
    input  mem_rdata, mem_ready,
    output owner, err
  );

  modport master (
    output cpu_addr, cpu_wdata, cpu_read, cpu_write,
    input  cpu_rdata, cpu_ready,
    output aux_addr, aux_wdata, aux_read, aux_write,
    input  aux_rdata, aux_ready,
    input  mem_addr, mem_wdata, mem_read, mem_write,
    output mem_rdata, mem_ready,
    input  owner, err
  );

endinterface

// File: rtl/axioma_dmem_arbiter.sv
// Data SRAM port arbiter. CPU has fixed priority; a starvation counter forces an AUX
// grant after STARVE_LIMIT consecutive lost arbitrations. A watchdog bounds each
// access (TIMEOUT = 0 disables it). Every output comes straight from a flop.
module axioma_dmem_arbiter
  import axioma_dmem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned STARVE_LIMIT = 4,   // 1..255
  parameter int unsigned TIMEOUT      = 255  // 0 disables the watchdog, max 255
) (
  input logic                  clk,
  input logic                  reset_n,
  axioma_dmem_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W:0]   WD_LIMIT   = (CNT_W + 1)'(TIMEOUT);
  localparam logic             WD_EN      = (TIMEOUT != 0);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic [CNT_W-1:0]  wd_q, wd_d;
  logic              owner_q, owner_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              cpu_ready_q, cpu_ready_d;
  logic [DATA_W-1:0] aux_rdata_q, aux_rdata_d;
  logic              aux_ready_q, aux_ready_d;

  // Arbitration results, only meaningful in ARB_IDLE.
  logic              cpu_pend, aux_pend;
  logic              aux_wins, cpu_wins, grant;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_read, sel_write;

  // Access completion, only meaningful in ARB_ACCESS.
  logic              wd_expired;
  logic              access_done;
  logic [DATA_W-1:0] resp_data;

  // Pick the winner and mux its operands.
  always_comb begin
    cpu_pend  = bus.cpu_read | bus.cpu_write;
    aux_pend  = bus.aux_read | bus.aux_write;
    aux_wins  = aux_takes_port(cpu_pend, aux_pend, starve_q, STARVE_LIM);
    cpu_wins  = cpu_pend && !aux_wins;
    grant     = aux_wins || cpu_wins;
    sel_addr  = bus.cpu_addr;
    sel_wdata = bus.cpu_wdata;
    sel_read  = bus.cpu_read;
    sel_write = bus.cpu_write;
    if (aux_wins) begin
      sel_addr  = bus.aux_addr;
      sel_wdata = bus.aux_wdata;
      sel_read  = bus.aux_read;
      sel_write = bus.aux_write;
    end
  end

  // Decide whether the current access ends this cycle and what data it returns.
  always_comb begin
    // The watchdog fires on the TIMEOUT-th ACCESS cycle without mem_ready.
    wd_expired  = WD_EN && (({1'b0, wd_q} + 1'b1) == WD_LIMIT);
    access_done = bus.mem_ready || wd_expired;
    resp_data   = '0;
    if (bus.mem_ready) begin
      // Writes complete with zero read data.
      resp_data = mem_read_q ? bus.mem_rdata : '0;
    end else if (wd_expired) begin
      resp_data = {DATA_W{1'b1}};
    end
  end

  // Next-state and registered-output logic for the arbiter FSM.
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    wd_d        = wd_q;
    owner_d     = owner_q;
    err_d       = err_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    cpu_rdata_d = cpu_rdata_q;
    aux_rdata_d = aux_rdata_q;
    cpu_ready_d = 1'b0;
    aux_ready_d = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        if (grant) begin
          owner_d     = aux_wins ? OWN_AUX : OWN_CPU;
          mem_addr_d  = sel_addr;
          mem_wdata_d = sel_wdata;
          // Read and write together is a protocol error; the write wins.
          mem_write_d = sel_write;
          mem_read_d  = sel_read && !sel_write;
          if (sel_read && sel_write) begin
            err_d = 1'b1;
          end
          wd_d    = '0;
          state_d = ARB_ACCESS;
        end
        if (aux_wins) begin
          starve_d = '0;
        end else if (cpu_wins && aux_pend) begin
          starve_d = sat_inc(starve_q);
        end
      end

      ARB_ACCESS: begin
        if (access_done) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          // A mem_ready in the expiry cycle counts as a normal completion.
          if (!bus.mem_ready) begin
            err_d = 1'b1;
          end
          if (owner_q == OWN_AUX) begin
            aux_ready_d = 1'b1;
            aux_rdata_d = resp_data;
          end else begin
            cpu_ready_d = 1'b1;
            cpu_rdata_d = resp_data;
          end
          state_d = ARB_RESP;
        end else begin
          wd_d = sat_inc(wd_q);
        end
      end

      ARB_RESP: begin
        state_d = ARB_IDLE;
      end

      default: begin
        state_d     = ARB_IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ARB_IDLE;
      starve_q    <= '0;
      wd_q        <= '0;
      owner_q     <= OWN_CPU;
      err_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      cpu_rdata_q <= '0;
      cpu_ready_q <= 1'b0;
      aux_rdata_q <= '0;
      aux_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      wd_q        <= wd_d;
      owner_q     <= owner_d;
      err_q       <= err_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_ready_q <= cpu_ready_d;
      aux_rdata_q <= aux_rdata_d;
      aux_ready_q <= aux_ready_d;
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.cpu_ready = cpu_ready_q;
  assign bus.aux_rdata = aux_rdata_q;
  assign bus.aux_ready = aux_ready_q;
  assign bus.owner     = owner_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_axioma_dmem_arbiter.sv
// Bench for axioma_dmem_arbiter: directed scenarios plus a randomized phase scored
// against a transaction-level model (who should be granted, what data comes back).
module tb_axioma_dmem_arbiter;

  localparam int unsigned ADDR_W       = 16;
  localparam int unsigned DATA_W       = 8;
  localparam int unsigned STARVE_LIMIT = 4;
  localparam int unsigned TIMEOUT      = 8;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  axioma_dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  axioma_dmem_arbiter #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .STARVE_LIMIT (STARVE_LIMIT),
    .TIMEOUT      (TIMEOUT)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // SRAM model
  logic [7:0] mem_arr [int];
  int acc_cyc    = 0;
  int cur_wait   = 0;
  int fixed_wait = 0;
  bit rand_wait  = 0;
  bit hang       = 0;

  function automatic logic [7:0] mem_val(input logic [15:0] a);
    if (mem_arr.exists(int'(a))) return mem_arr[int'(a)];
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, sample just after the edge, then play the SRAM for this cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.mem_read || bus.mem_write) begin
      if (acc_cyc == 0) cur_wait = rand_wait ? int'($urandom_range(0, 3)) : fixed_wait;
      acc_cyc++;
      if (!hang && acc_cyc > cur_wait) begin
        bus.mem_ready = 1'b1;
        if (bus.mem_write) begin
          mem_arr[int'(bus.mem_addr)] = bus.mem_wdata;
          bus.mem_rdata = 8'($urandom);
        end else begin
          bus.mem_rdata = mem_val(bus.mem_addr);
        end
      end else begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 8'($urandom);
      end
    end else begin
      acc_cyc       = 0;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = 8'($urandom);
    end
  endtask

  task automatic wait_ready(input string tag, output bit got_aux);
    int n = 0;
    while (!(bus.cpu_ready || bus.aux_ready) && n < 40) begin
      tick();
      n++;
    end
    check({tag, " ready within bound"}, 32'(n < 40), 1);
    got_aux = bus.aux_ready;
  endtask

  initial begin
    #500000;
    $display("FAIL global time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    bit   ga;
    int   n;
    int   served_cpu;
    bit   seen;
    // random-phase state
    bit          cpu_req, aux_req, c_wr, a_wr, p_cpu, p_aux, prev_strobe, strobe;
    bit          in_flight, exp_aux_own, draining;
    logic [15:0] c_addr, a_addr, g_addr;
    logic [7:0]  c_wd, a_wd, g_wd, exp_rdata;
    bit          g_wr;
    int          c_gap, a_gap, starve, served, cyc;

    bus.cpu_addr  = '0; bus.cpu_wdata = '0; bus.cpu_read = 0; bus.cpu_write = 0;
    bus.aux_addr  = '0; bus.aux_wdata = '0; bus.aux_read = 0; bus.aux_write = 0;
    bus.mem_rdata = '0; bus.mem_ready = 0;
    mem_arr[int'(16'h0120)] = 8'hA5;
    reset_n = 1'b0;

    // Reset state
    #12;
    check("rst mem_read",  32'(bus.mem_read),  0);
    check("rst mem_write", 32'(bus.mem_write), 0);
    check("rst mem_addr",  32'(bus.mem_addr),  0);
    check("rst owner",     32'(bus.owner),     0);
    check("rst err",       32'(bus.err),       0);
    check("rst readies",   32'({bus.cpu_ready, bus.aux_ready}), 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    tick();

    // 1: zero-wait CPU read
    bus.cpu_addr = 16'h0120;
    bus.cpu_read = 1'b1;
    tick();
    check("t1 mem_read",  32'(bus.mem_read),  1);
    check("t1 mem_write", 32'(bus.mem_write), 0);
    check("t1 mem_addr",  32'(bus.mem_addr),  'h0120);
    check("t1 owner",     32'(bus.owner),     0);
    check("t1 early ready", 32'(bus.cpu_ready), 0);
    tick();
    check("t1 cpu_ready", 32'(bus.cpu_ready), 1);
    check("t1 cpu_rdata", 32'(bus.cpu_rdata), 'hA5);
    check("t1 aux_ready", 32'(bus.aux_ready), 0);
    check("t1 err",       32'(bus.err),       0);
    bus.cpu_read = 1'b0;
    tick();
    check("t1 ready one cycle", 32'(bus.cpu_ready), 0);

    // mem_ready while idle has no effect
    bus.mem_ready = 1'b1;
    tick();
    check("idle mem_ready readies", 32'({bus.cpu_ready, bus.aux_ready}), 0);
    check("idle mem_ready strobes", 32'({bus.mem_read, bus.mem_write}), 0);

    // 2: simultaneous requests, CPU first then AUX immediately after
    bus.cpu_addr = 16'h0200; bus.cpu_wdata = 8'h3C; bus.cpu_write = 1'b1;
    bus.aux_addr = 16'h0300; bus.aux_read = 1'b1;
    tick();
    check("t2 owner cpu",  32'(bus.owner),     0);
    check("t2 mem_write",  32'(bus.mem_write), 1);
    check("t2 mem_addr",   32'(bus.mem_addr),  'h0200);
    check("t2 mem_wdata",  32'(bus.mem_wdata), 'h3C);
    tick();
    check("t2 cpu_ready",  32'(bus.cpu_ready), 1);
    check("t2 cpu_rdata",  32'(bus.cpu_rdata), 0);
    check("t2 aux not yet", 32'(bus.aux_ready), 0);
    bus.cpu_write = 1'b0;
    tick();
    tick();
    check("t2 owner aux",  32'(bus.owner),     1);
    check("t2 aux mem_read", 32'(bus.mem_read), 1);
    check("t2 aux mem_addr", 32'(bus.mem_addr), 'h0300);
    tick();
    check("t2 aux_ready",  32'(bus.aux_ready), 1);
    check("t2 aux_rdata",  32'(bus.aux_rdata), 32'(mem_val(16'h0300)));
    check("t2 cpu idle",   32'(bus.cpu_ready), 0);
    check("t2 sram got write", 32'(mem_val(16'h0200)), 'h3C);
    bus.aux_read = 1'b0;
    tick();

    // 3: CPU hammers the port while AUX waits; AUX wins the fifth arbitration
    bus.aux_addr = 16'h0444; bus.aux_read = 1'b1;
    served_cpu = 0;
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      bus.cpu_addr = 16'h0100 + 16'(i);
      bus.cpu_read = 1'b1;
      wait_ready("t3", ga);
      if (ga) begin
        seen = 1;
        check("t3 aux_rdata", 32'(bus.aux_rdata), 32'(mem_val(16'h0444)));
        bus.aux_read = 1'b0;
      end else begin
        served_cpu++;
        bus.cpu_read = 1'b0;
      end
      tick();
    end
    check("t3 aux granted", 32'(seen), 1);
    check("t3 cpu wins before aux", 32'(served_cpu), STARVE_LIMIT);
    // Counter cleared: with both pending again the CPU wins
    bus.aux_addr = 16'h0448; bus.aux_read = 1'b1;
    wait_ready("t3 post", ga);
    check("t3 cpu wins after clear", 32'(ga), 0);
    bus.cpu_read = 1'b0;
    tick();
    wait_ready("t3 post aux", ga);
    check("t3 aux follows", 32'(ga), 1);
    bus.aux_read = 1'b0;
    tick();

    // Randomized traffic against the transaction model
    rand_wait = 1;
    cpu_req = 0; aux_req = 0; c_wr = 0; a_wr = 0; p_cpu = 0; p_aux = 0;
    prev_strobe = 0; in_flight = 0; exp_aux_own = 0; draining = 0;
    c_addr = '0; a_addr = '0; c_wd = '0; a_wd = '0; g_addr = '0; g_wd = '0; g_wr = 0;
    exp_rdata = '0;
    c_gap = 1; a_gap = 2; starve = 0; served = 0;
    cyc = 0;
    while (cyc < 2500 && !(draining && !cpu_req && !aux_req && !in_flight)) begin
      tick();
      cyc++;
      draining = (cyc >= 1500);
      strobe = bus.mem_read || bus.mem_write;
      if (strobe && !prev_strobe) begin
        check("rnd grant had a requester", 32'(p_cpu || p_aux), 1);
        check("rnd single in flight", 32'(in_flight), 0);
        exp_aux_own = p_aux && (starve >= int'(STARVE_LIMIT) || !p_cpu);
        if (exp_aux_own) starve = 0;
        else if (p_aux) starve = (starve < 255) ? starve + 1 : 255;
        g_addr = exp_aux_own ? a_addr : c_addr;
        g_wd   = exp_aux_own ? a_wd : c_wd;
        g_wr   = exp_aux_own ? a_wr : c_wr;
        check("rnd owner",     32'(bus.owner),     32'(exp_aux_own));
        check("rnd mem_addr",  32'(bus.mem_addr),  32'(g_addr));
        check("rnd mem_write", 32'(bus.mem_write), 32'(g_wr));
        check("rnd mem_read",  32'(bus.mem_read),  32'(!g_wr));
        if (g_wr) check("rnd mem_wdata", 32'(bus.mem_wdata), 32'(g_wd));
        exp_rdata = g_wr ? 8'h00 : mem_val(g_addr);
        in_flight = 1;
      end
      if (bus.cpu_ready || bus.aux_ready) begin
        check("rnd ready expected", 32'(in_flight), 1);
        check("rnd ready owner", 32'({bus.aux_ready, bus.cpu_ready}),
              exp_aux_own ? 32'd2 : 32'd1);
        check("rnd rdata", exp_aux_own ? 32'(bus.aux_rdata) : 32'(bus.cpu_rdata),
              32'(exp_rdata));
        in_flight = 0;
        served++;
        if (exp_aux_own) begin
          aux_req = 0;
          a_gap = int'($urandom_range(1, 6));
        end else begin
          cpu_req = 0;
          c_gap = int'($urandom_range(1, 3));
        end
      end
      if (!cpu_req) begin
        if (c_gap > 0) c_gap--;
        else if (!draining) begin
          cpu_req = 1;
          c_addr  = 16'h0600 + 16'($urandom_range(0, 15));
          c_wr    = 1'($urandom_range(0, 1));
          c_wd    = 8'($urandom);
        end
      end
      if (!aux_req) begin
        if (a_gap > 0) a_gap--;
        else if (!draining) begin
          aux_req = 1;
          a_addr  = 16'h0600 + 16'($urandom_range(0, 15));
          a_wr    = 1'($urandom_range(0, 1));
          a_wd    = 8'($urandom);
        end
      end
      bus.cpu_addr  = c_addr; bus.cpu_wdata = c_wd;
      bus.cpu_read  = cpu_req && !c_wr; bus.cpu_write = cpu_req && c_wr;
      bus.aux_addr  = a_addr; bus.aux_wdata = a_wd;
      bus.aux_read  = aux_req && !a_wr; bus.aux_write = aux_req && a_wr;
      p_cpu = cpu_req;
      p_aux = aux_req;
      prev_strobe = strobe;
    end
    check("rnd drained", 32'({cpu_req, aux_req, in_flight}), 0);
    check("rnd enough traffic", 32'(served >= 50), 1);
    check("rnd err clear", 32'(bus.err), 0);
    rand_wait = 0;
    tick();

    // 4: watchdog on an AUX read the SRAM never answers
    hang = 1;
    bus.aux_addr = 16'h0500; bus.aux_read = 1'b1;
    tick();
    n = 0;
    while (bus.mem_read && n < 20) begin
      n++;
      tick();
    end
    check("t4 strobe cycles", 32'(n), TIMEOUT);
    check("t4 aux_ready", 32'(bus.aux_ready), 1);
    check("t4 aux_rdata", 32'(bus.aux_rdata), 'hFF);
    check("t4 err",       32'(bus.err),       1);
    bus.aux_read = 1'b0;
    hang = 0;
    tick();
    check("t4 ready one cycle", 32'(bus.aux_ready), 0);
    check("t4 err sticky", 32'(bus.err), 1);

    // 6: reset mid-access aborts without a ready
    fixed_wait = 5;
    bus.aux_addr = 16'h0600; bus.aux_read = 1'b1;
    tick();
    check("t6 access started", 32'({bus.owner, bus.mem_read}), 'h3);
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("t6 strobes drop", 32'({bus.mem_read, bus.mem_write}), 0);
    check("t6 owner",        32'(bus.owner),    0);
    check("t6 mem_addr",     32'(bus.mem_addr), 0);
    check("t6 err cleared",  32'(bus.err),      0);
    bus.aux_read = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.cpu_ready || bus.aux_ready) seen = 1;
    end
    check("t6 no ready after abort", 32'(seen), 0);
    fixed_wait = 0;
    bus.cpu_addr = 16'h0120; bus.cpu_read = 1'b1;
    tick();
    tick();
    check("t6 next cpu_ready", 32'(bus.cpu_ready), 1);
    check("t6 next cpu_rdata", 32'(bus.cpu_rdata), 'hA5);
    bus.cpu_read = 1'b0;
    tick();

    // 5: read and write together -> write performed, err set
    bus.cpu_addr = 16'h0010; bus.cpu_wdata = 8'h77;
    bus.cpu_read = 1'b1; bus.cpu_write = 1'b1;
    tick();
    check("t5 mem_write", 32'(bus.mem_write), 1);
    check("t5 mem_read",  32'(bus.mem_read),  0);
    check("t5 mem_wdata", 32'(bus.mem_wdata), 'h77);
    check("t5 err",       32'(bus.err),       1);
    tick();
    check("t5 cpu_ready", 32'(bus.cpu_ready), 1);
    check("t5 cpu_rdata", 32'(bus.cpu_rdata), 0);
    bus.cpu_read = 1'b0; bus.cpu_write = 1'b0;
    tick();
    check("t5 sram got write", 32'(mem_val(16'h0010)), 'h77);
    check("t5 err sticky", 32'(bus.err), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
